// File: rtl/encoder_8para3_rr_pkg.sv
// Shared constants, FSM state type and popcount helper for the 8-to-3
// round-robin request encoder.
package encoder_8para3_rr_pkg;

    localparam int N_LINES = 8;
    localparam int CODE_W  = 3;
    localparam int CNT_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } enc_state_e;

    function automatic logic [CNT_W-1:0] popcount8(input logic [N_LINES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_LINES; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/encoder_8para3_rr_rr_pick8.sv
// Combinational rotating-priority picker: first set bit of pending_i
// scanning upward from ptr_i, wrapping mod 8.
module rr_pick8
    import encoder_8para3_rr_pkg::*;
(
    input  logic [N_LINES-1:0] pending_i,
    input  logic [CODE_W-1:0]  ptr_i,
    output logic               any_o,
    output logic [CODE_W-1:0]  idx_o
);

    logic [2*N_LINES-1:0] dbl;
    logic [N_LINES-1:0]   rot;
    logic [CODE_W-1:0]    off;

    // Rotate so the ptr line lands at bit 0; the lowest set bit of rot is
    // then the offset from ptr of the winning line.
    always_comb begin
        dbl = {pending_i, pending_i} >> ptr_i;
        rot = dbl[N_LINES-1:0];
        off = '0;
        for (int j = N_LINES - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = CODE_W'(j);
            end
        end
        any_o = |pending_i;
        idx_o = ptr_i + off;
    end

endmodule

// File: rtl/encoder_8para3_rr.sv
// Sequential 8-to-3 request encoder: sticky pending lines, round-robin
// grant, binary index offered on a valid/ready handshake.
module encoder_8para3_rr
    import encoder_8para3_rr_pkg::*;
#(
    parameter int unsigned RESET_PTR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LINES-1:0] req_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [CODE_W-1:0]  code_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               drop_o
);

    enc_state_e          state_q;
    logic [N_LINES-1:0]  pending_q, pending_d;
    logic [CODE_W-1:0]   ptr_q;
    logic                valid_q;
    logic [CODE_W-1:0]   code_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                drop_q, drop_d;

    logic                accept;
    logic [N_LINES-1:0]  clr_mask;
    logic                pick_any;
    logic [CODE_W-1:0]   pick_idx;

    // Picks only from registered pending, so late arrivals never preempt.
    rr_pick8 u_pick (
        .pending_i (pending_q),
        .ptr_i     (ptr_q),
        .any_o     (pick_any),
        .idx_o     (pick_idx)
    );

    // A same-edge re-request of the line being accepted keeps it pending
    // and is not counted as a drop.
    always_comb begin
        accept   = (state_q == OFFER) && ready_i;
        clr_mask = '0;
        if (accept) begin
            clr_mask[code_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr_mask) | req_i;
        drop_d    = |(req_i & pending_q & ~clr_mask);
        count_d   = popcount8(pending_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= CODE_W'(RESET_PTR);
            valid_q   <= 1'b0;
            code_q    <= '0;
            count_q   <= '0;
            drop_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        code_q  <= pick_idx;
                        valid_q <= 1'b1;
                        state_q <= OFFER;
                    end
                end
                OFFER: begin
                    if (ready_i) begin
                        ptr_q   <= code_q + 3'd1;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_o = valid_q;
    assign code_o  = code_q;
    assign count_o = count_q;
    assign drop_o  = drop_q;

endmodule

// File: tb/tb_encoder_8para3_rr.sv
// Directed bench for encoder_8para3_rr: per-cycle vector table plus
// hand-written reset sequences.
module tb_encoder_8para3_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_i;
    logic       ready_i;
    logic       valid_o;
    logic [2:0] code_o;
    logic [3:0] count_o;
    logic       drop_o;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       v;
        logic [2:0] c;
        logic [3:0] n;
        logic       d;
    } vec_t;

    vec_t tv[$];

    encoder_8para3_rr #(.RESET_PTR(0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_i),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .code_o  (code_o),
        .count_o (count_o),
        .drop_o  (drop_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [7:0] req, input logic rdy, input logic v,
                                input logic [2:0] c, input logic [3:0] n, input logic d);
        vec_t t;
        t.req = req; t.rdy = rdy; t.v = v; t.c = c; t.n = n; t.d = d;
        tv.push_back(t);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Burst from ptr=0: codes 0..7, one per two cycles, count 8 -> 0
        add(8'hFF, 1, 0, 0, 8, 0);
        for (int k = 0; k < 8; k++) begin
            add(8'h00, 1, 1, 3'(k), 4'(8 - k), 0);
            add(8'h00, 1, 0, 0, 4'(7 - k), 0);
        end
        // Single request on line 5, held offer, then accept
        add(8'h20, 0, 0, 0, 1, 0);
        for (int k = 0; k < 10; k++) add(8'h00, 0, 1, 5, 1, 0);
        add(8'h00, 1, 0, 0, 0, 0);
        add(8'h00, 1, 0, 0, 0, 0);
        // Round robin: grant 3 (ptr=6), 0x42 arrives during offer -> 6 then 1
        add(8'h08, 0, 0, 0, 1, 0);
        add(8'h00, 0, 1, 3, 1, 0);
        add(8'h42, 0, 1, 3, 3, 0);
        add(8'h00, 0, 1, 3, 3, 0);
        add(8'h00, 1, 0, 0, 2, 0);
        add(8'h00, 0, 1, 6, 2, 0);
        add(8'h00, 1, 0, 0, 1, 0);
        add(8'h00, 0, 1, 1, 1, 0);
        add(8'h00, 1, 0, 0, 0, 0);
        // Drop while pending, then same-edge re-request on accept of code 2
        add(8'h08, 0, 0, 0, 1, 0);
        add(8'h44, 0, 1, 3, 3, 0);
        add(8'h04, 0, 1, 3, 3, 1);
        add(8'h00, 0, 1, 3, 3, 0);
        add(8'h00, 1, 0, 0, 2, 0);
        add(8'h00, 0, 1, 6, 2, 0);
        add(8'h00, 1, 0, 0, 1, 0);
        add(8'h00, 0, 1, 2, 1, 0);
        add(8'h04, 1, 0, 0, 1, 0);
        add(8'h00, 0, 1, 2, 1, 0);
        add(8'h00, 1, 0, 0, 0, 0);

        // Reset with all requests high: outputs stay cleared
        rst_n = 1'b0; req_i = 8'hFF; ready_i = 1'b0;
        tick; tick;
        chk("rst_valid", {7'b0, valid_o}, 8'h0);
        chk("rst_code",  {5'b0, code_o},  8'h0);
        chk("rst_count", {4'b0, count_o}, 8'h0);
        chk("rst_drop",  {7'b0, drop_o},  8'h0);
        req_i = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("post_rst_valid%0d", k), {7'b0, valid_o}, 8'h0);
            chk($sformatf("post_rst_count%0d", k), {4'b0, count_o}, 8'h0);
        end

        foreach (tv[i]) begin
            req_i   = tv[i].req;
            ready_i = tv[i].rdy;
            tick;
            chk($sformatf("v%0d_valid", i), {7'b0, valid_o}, {7'b0, tv[i].v});
            if (tv[i].v) chk($sformatf("v%0d_code", i), {5'b0, code_o}, {5'b0, tv[i].c});
            chk($sformatf("v%0d_count", i), {4'b0, count_o}, {4'b0, tv[i].n});
            chk($sformatf("v%0d_drop", i), {7'b0, drop_o}, {7'b0, tv[i].d});
        end

        // Reset mid-OFFER: fresh start, 0x0F offers code 0, async clear
        req_i = 8'h00; ready_i = 1'b0;
        rst_n = 1'b0;
        tick;
        @(negedge clk);
        rst_n = 1'b1;
        req_i = 8'h0F;
        tick;
        req_i = 8'h00;
        chk("mid_pre_count", {4'b0, count_o}, 8'h4);
        chk("mid_pre_valid", {7'b0, valid_o}, 8'h0);
        tick;
        chk("mid_offer_valid", {7'b0, valid_o}, 8'h1);
        chk("mid_offer_code",  {5'b0, code_o},  8'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_valid", {7'b0, valid_o}, 8'h0);
        chk("mid_async_count", {4'b0, count_o}, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("mid_after_valid%0d", k), {7'b0, valid_o}, 8'h0);
            chk($sformatf("mid_after_count%0d", k), {4'b0, count_o}, 8'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
